uart_vctr_rx: RTL

UART_VCTR_RX -- requirements
Module: uart_vctr_rx

---
 rtl/uart_vctr_rx.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_vctr_rx.sv
// uart_vctr_rx: UART receiver feeding a framed vector assembler.
//
// A frame is a header byte 0xA<ch> (ch < NUM_CH) followed by VEC_BYTES data
// bytes; the first data byte lands in the MSBs of vec_data. With the macro
// UART_VCTR_CHKSUM_EN defined, a trailing XOR checksum byte (header ^ data)
// is also required, and a mismatch pulses err_chk.
//
// Ports:
//   clock, rst      sole rising-edge clock, asynchronous active-high reset
//   rx              raw asynchronous UART line (idle high)
//   rx_data         last byte received with a good stop bit
//   rx_byte_valid   one-cycle pulse per accepted byte
//   vec_data/vec_ch assembled vector and its channel, stable while vec_valid
//   vec_valid/vec_ready  output handshake
//   err_frame/err_hdr/err_ovr/err_tmo/err_chk  one-cycle error pulses
module uart_vctr_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int VEC_BYTES    = 4,
  parameter int NUM_CH       = 2,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   rx,
  output logic [7:0]             rx_data,
  output logic                   rx_byte_valid,
  output logic [8*VEC_BYTES-1:0] vec_data,
  output logic [3:0]             vec_ch,
  output logic                   vec_valid,
  input  logic                   vec_ready,
  output logic                   err_frame,
  output logic                   err_hdr,
  output logic                   err_ovr,
  output logic                   err_tmo,
  output logic                   err_chk
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int VW = 8 * VEC_BYTES;
  localparam int TW = $clog2(TIMEOUT_BITS + 2) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // Line synchroniser; rx_prev gives the edge detector its history.
  logic rx_meta, rx_s, rx_prev;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // ---------------- byte receiver ----------------
  typedef enum logic [2:0] {U_IDLE, U_START, U_BITS, U_STOP, U_WAIT} u_state_t;
  u_state_t u_state, u_next;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          cnt_clr, bit_take, stop_ok, stop_bad;

  always_comb begin
    u_next   = u_state;
    cnt_clr  = 1'b0;
    bit_take = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (u_state)
      U_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_prev && !rx_s) u_next = U_START;
      end
      U_START: begin
        if (clk_cnt == CNT_HALF) begin
          cnt_clr = 1'b1;
          u_next  = rx_s ? U_IDLE : U_BITS;
        end
      end
      U_BITS: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_clr  = 1'b1;
          bit_take = 1'b1;
          if (bit_idx == 3'd7) u_next = U_STOP;
        end
      end
      U_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            stop_ok = 1'b1;
            u_next  = U_IDLE;
          end else begin
            stop_bad = 1'b1;
            u_next   = U_WAIT;
          end
        end
      end
      U_WAIT: begin
        cnt_clr = 1'b1;
        if (rx_s) u_next = U_IDLE;
      end
      default: u_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      u_state       <= U_IDLE;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_byte_valid <= 1'b0;
      err_frame     <= 1'b0;
    end else begin
      u_state <= u_next;
      clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
      if (u_state == U_IDLE) begin
        bit_idx <= '0;
      end else if (bit_take) begin
        bit_idx <= bit_idx + 1'b1;
        shift   <= {rx_s, shift[7:1]};
      end
      rx_byte_valid <= stop_ok;
      err_frame     <= stop_bad;
      if (stop_ok) rx_data <= shift;
    end
  end

  // ---------------- frame assembler ----------------
`ifdef UART_VCTR_CHKSUM_EN
  typedef enum logic [1:0] {F_HDR, F_DATA, F_CHK, F_PUSH} f_state_t;
`else
  typedef enum logic [1:0] {F_HDR, F_DATA, F_PUSH} f_state_t;
`endif
  f_state_t f_state, f_next;
  logic [4:0]    byte_cnt;
  logic [3:0]    ch_q;
  logic [VW-1:0] vec_sh, vec_shift_in;
  logic [CW-1:0] tick_cnt;
  logic [TW-1:0] idle_bits;
  logic          in_frame, tmo_hit, hdr_match;
  logic          hdr_ok, hdr_bad, data_take, push_load, push_ovr, tmo_fire;

  generate
    if (VEC_BYTES == 1) begin : g_shift1
      assign vec_shift_in = rx_data;
    end else begin : g_shiftn
      assign vec_shift_in = {vec_sh[VW-9:0], rx_data};
    end
  endgenerate

  assign hdr_match = (rx_data[7:4] == 4'hA) && ({1'b0, rx_data[3:0]} < 5'(NUM_CH));
  assign tmo_hit   = idle_bits > TW'(TIMEOUT_BITS);

`ifdef UART_VCTR_CHKSUM_EN
  logic [7:0] chk_acc;
  logic       chk_bad;
  assign in_frame = (f_state == F_DATA) || (f_state == F_CHK);
`else
  assign in_frame = (f_state == F_DATA);
  assign err_chk  = 1'b0;
`endif

  always_comb begin
    f_next    = f_state;
    hdr_ok    = 1'b0;
    hdr_bad   = 1'b0;
    data_take = 1'b0;
    push_load = 1'b0;
    push_ovr  = 1'b0;
    tmo_fire  = 1'b0;
`ifdef UART_VCTR_CHKSUM_EN
    chk_bad   = 1'b0;
`endif
    case (f_state)
      F_HDR: begin
        if (rx_byte_valid) begin
          if (hdr_match) begin
            hdr_ok = 1'b1;
            f_next = F_DATA;
          end else begin
            hdr_bad = 1'b1;
          end
        end
      end
      F_DATA: begin
        if (err_frame) begin
          f_next = F_HDR;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          f_next   = F_HDR;
        end else if (rx_byte_valid) begin
          data_take = 1'b1;
          if (byte_cnt == 5'(VEC_BYTES - 1)) begin
`ifdef UART_VCTR_CHKSUM_EN
            f_next = F_CHK;
`else
            f_next = F_PUSH;
`endif
          end
        end
      end
`ifdef UART_VCTR_CHKSUM_EN
      F_CHK: begin
        if (err_frame) begin
          f_next = F_HDR;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          f_next   = F_HDR;
        end else if (rx_byte_valid) begin
          if (rx_data == chk_acc) begin
            f_next = F_PUSH;
          end else begin
            chk_bad = 1'b1;
            f_next  = F_HDR;
          end
        end
      end
`endif
      F_PUSH: begin
        // A same-cycle handshake frees the output register for this frame.
        if (!vec_valid || vec_ready) push_load = 1'b1;
        else                         push_ovr  = 1'b1;
        f_next = F_HDR;
      end
      default: f_next = F_HDR;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      f_state   <= F_HDR;
      byte_cnt  <= '0;
      ch_q      <= '0;
      vec_sh    <= '0;
      tick_cnt  <= '0;
      idle_bits <= '0;
      vec_data  <= '0;
      vec_ch    <= '0;
      vec_valid <= 1'b0;
      err_hdr   <= 1'b0;
      err_ovr   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      f_state <= f_next;
      err_hdr <= hdr_bad;
      err_ovr <= push_ovr;
      err_tmo <= tmo_fire;

      if (hdr_ok) begin
        ch_q     <= rx_data[3:0];
        byte_cnt <= '0;
      end else if (data_take) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (data_take) vec_sh <= vec_shift_in;

      // Inter-byte timer: whole bit periods since the last accepted byte.
      if (!in_frame || rx_byte_valid) begin
        tick_cnt  <= '0;
        idle_bits <= '0;
      end else if (tick_cnt == CNT_LAST) begin
        tick_cnt  <= '0;
        idle_bits <= idle_bits + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (push_load) begin
        vec_data  <= vec_sh;
        vec_ch    <= ch_q;
        vec_valid <= 1'b1;
      end else if (vec_valid && vec_ready) begin
        vec_valid <= 1'b0;
      end
    end
  end

`ifdef UART_VCTR_CHKSUM_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      chk_acc <= '0;
      err_chk <= 1'b0;
    end else begin
      err_chk <= chk_bad;
      if (hdr_ok)         chk_acc <= rx_data;
      else if (data_take) chk_acc <= chk_acc ^ rx_data;
    end
  end
`endif

endmodule
